// File: rtl/axis_dac_pulse_player_if.sv
// axis_dac_pulse_player_if: single AXI-stream link (data, valid, ready)
interface axis_dac_pulse_player_if #(parameter int W = 256);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_dac_pulse_player.sv
// axis_dac_pulse_player: on trigger, waits delay cycles then plays pulse_len FIFO words to the DAC,
// substituting zeros (and counting underflows) when the FIFO runs dry.
module axis_dac_pulse_player #(
  parameter int LEN_W = 16
) (
  input  logic                         axis_clk,
  input  logic                         rst,
  input  logic                         trigger,
  input  logic [LEN_W-1:0]             pulse_len,
  input  logic [LEN_W-1:0]             delay,
  input  logic                         clr_status,
  axis_dac_pulse_player_if.slave       s_axis,
  axis_dac_pulse_player_if.master      m_axis,
  output logic                         busy,
  output logic                         underflow,
  output logic [LEN_W-1:0]             underflow_cnt,
  output logic                         trig_dropped
);
  typedef enum logic [1:0] {IDLE, DELAY, PLAY} state_t;
  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, ucnt_q, ucnt_d;
  logic [255:0]       tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d, uf_q, uf_d, drop_q, drop_d, play, uf;
  assign play = state_q == PLAY;
  assign uf = play && !s_axis.tvalid;
  assign s_axis.tready = play;
  assign m_axis.tdata = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign busy = state_q != IDLE;
  assign underflow = uf_q;
  assign underflow_cnt = ucnt_q;
  assign trig_dropped = drop_q;
  // cnt serves as the delay counter in DELAY and the length counter in PLAY
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (trigger && pulse_len != '0) begin
        len_d = pulse_len;
        state_d = delay != '0 ? DELAY : PLAY;
        cnt_d = delay != '0 ? delay : pulse_len;
      end
      DELAY: begin
        state_d = cnt_q == LEN_W'(1) ? PLAY : DELAY;
        cnt_d = cnt_q == LEN_W'(1) ? len_q : cnt_q - 1'b1;
      end
      default: begin
        state_d = cnt_q == LEN_W'(1) ? IDLE : PLAY;
        cnt_d = cnt_q - 1'b1;
      end
    endcase
  end
  // a status set in the same cycle as clr_status wins over the clear
  always_comb begin
    tdata_d = play && s_axis.tvalid ? s_axis.tdata : '0;
    tvalid_d = play;
    uf_d = uf || (uf_q && !clr_status);
    ucnt_d = uf ? (clr_status ? LEN_W'(1) : (ucnt_q == '1 ? ucnt_q : ucnt_q + 1'b1))
                : (clr_status ? '0 : ucnt_q);
    drop_d = (trigger && busy) || (drop_q && !clr_status);
  end
  always_ff @(posedge axis_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      ucnt_q <= '0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      uf_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      ucnt_q <= ucnt_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      uf_q <= uf_d;
      drop_q <= drop_d;
    end
  end
endmodule
